pe_rr_arbiter: RTL and testbench
================================

Name: pe_rr_arbiter

Overview:
Round-robin arbiter that shares one downstream resource among N requesters, default 3. It builds on the team's 3-input priority-encoder datapath: the encoder picks the winner and this block adds the sequencing around it. That sequencing covers rotating priority, grant hold, a hold-time limit and enable gating. The block sits between requesting units and the shared resource and produces registered one-hot and encoded grants.

Parameters:
N, 3, number of requesters (2..8)
ID_W, 2, encoded grant width = clog2(N)
MAX_HOLD, 4, max consecutive cycles one holder keeps the grant while others wait (>=1)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
en  input  1  1 = new grants may be issued; 0 = no new grants, an existing grant continues
req  input  N  request vector, bit i = requester i, level-sensitive
gnt  output  N  one-hot grant, registered
gnt_id  output  ID_W  binary index of the granted requester, registered, 0 when gnt_vld=0
gnt_vld  output  1  a grant is active

Behaviour:
- Reset: clk and rst form one clock domain; reset is synchronous and active-high.
- Reset values: gnt=0, gnt_id=0, gnt_vld=0, state=IDLE, last_id=N-1 (requester 0 has top priority first), hold_cnt=0.
- Reset mid-grant: reset wins over everything. Outputs return to reset values on that edge and any in-flight grant is dropped.
- States: IDLE and GRANT.
- IDLE to GRANT: at an edge where en=1 and req!=0.
  - Winner = first set bit scanning last_id+1, last_id+2, ... modulo N.
  - gnt/gnt_id/gnt_vld update on that edge, so latency is 1 cycle from a sampled request.
  - hold_cnt=0 and last_id=winner.
- GRANT, holder's req still high:
  - hold_cnt increments on each edge.
  - If hold_cnt==MAX_HOLD-1 and any other req bit is set and en=1, the grant moves directly to the next round-robin winner with the holder excluded. No idle cycle; hold_cnt=0.
  - If no other requester is pending, or en=0, the holder keeps the grant and hold_cnt saturates at MAX_HOLD-1.
- GRANT, holder's req low at an edge:
  - If en=1 and other requests exist, re-arbitrate on the same edge: back-to-back grant to the next winner, hold_cnt=0.
  - Otherwise go to IDLE with gnt=0, gnt_vld=0, gnt_id=0.
- en=0 while in IDLE: stay in IDLE regardless of req.
- Simultaneous release and new request: the new request is eligible on the same edge.
- A requester that deasserts before being granted is simply never granted; there is no request latching.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_vld == |gnt.
  - gnt[gnt_id] == 1 whenever gnt_vld=1.
- Fairness: with all N requesters held high, each one receives exactly MAX_HOLD cycles per turn in order 0,1,...,N-1,0,...
- Inputs are sampled only at rising edges. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package pe_arb_pkg holds:
  - state encoding constants ST_IDLE=0, ST_GRANT=1;
  - a clog2 function used to derive ID_W.
- One sub-module, pe_rot_encoder (combinational). Inputs: req[N-1:0] and start[ID_W-1:0]. Outputs: id, valid. It is a rotated priority encoder generalizing the 3-to-2 encoder and is reused for both initial and handover arbitration.
- The arbiter instantiates it once, with req masked by the holder's bit during handover.

Test Plan:
1. Reset release, then req=3'b111, en=1 held → gnt_id runs 0 for 4 cycles, then 1×4, then 2×4, then 0; gnt_vld stays 1 with no gaps.
2. req=3'b010 for 2 cycles, then 0 → gnt=3'b010 and gnt_id=1 one cycle after first sample; gnt_vld=0 one edge after req drops.
3. Holder 0 drops req on the same edge req[2] rises (req 3'b001→3'b100) → next cycle gnt=3'b100, gnt_id=2, with no gnt_vld=0 cycle.
4. req=3'b001 alone for 10 cycles → grant stays on 0 for all 10 cycles; there is no forced release because nobody else waits.
5. en=0 with req=3'b110 → gnt_vld stays 0. Raise en → gnt_id=1 on the next edge. Drop en during the grant → the holder keeps it past MAX_HOLD.
6. rst asserted while gnt_id=2 → all outputs 0 on the next edge. After release, req=3'b101 → gnt_id=0, because last_id was reset to 2.

Source files
------------

// File: rtl/pe_rr_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pe_arb_pkg                                                      |
// | Purpose  : Shared types and helpers for the round-robin arbiter slice:     |
// |            FSM state encoding and a constant clog2 used to size fields.    |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package pe_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Ceiling log2; clog2(1) = 0, clog2(3) = 2, clog2(5) = 3.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage : pe_arb_pkg
`default_nettype wire

// File: rtl/pe_rr_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pe_rr_arbiter_if                                                |
// | Purpose  : Request/grant bundle between requesting units and the arbiter. |
// | Ports    : en, req[N-1:0]            (requester side drives)               |
// |            gnt[N-1:0], gnt_id, gnt_vld (arbiter side drives)               |
// |            master = requester view, slave = arbiter view                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface pe_rr_arbiter_if #(
  parameter int N    = 3,
  parameter int ID_W = 2
);

  logic            en;
  logic [N-1:0]    req;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_vld;

  modport master (
    output en,
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_vld
  );

  modport slave (
    input  en,
    input  req,
    output gnt,
    output gnt_id,
    output gnt_vld
  );

endinterface : pe_rr_arbiter_if
`default_nettype wire

// File: rtl/pe_rr_arbiter_rot_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pe_rot_encoder                                                  |
// | Purpose  : Rotated priority encoder. Returns the first set request bit     |
// |            scanning start, start+1, ... modulo N. Purely combinational.    |
// | Ports    : req[N-1:0]  in   request vector                                 |
// |            start       in   first index to scan (must be < N)              |
// |            id          out  winning index (0 when valid = 0)               |
// |            valid       out  at least one request bit set                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pe_rot_encoder
  import pe_arb_pkg::*;
#(
  parameter int N    = 3,
  parameter int ID_W = clog2(N)
) (
  input  wire logic [N-1:0]    req,
  input  wire logic [ID_W-1:0] start,
  output logic      [ID_W-1:0] id,
  output logic                 valid
);

  always_comb begin
    int idx;
    id    = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      // Wrap start+k back into 0..N-1 without a modulo operator.
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        id    = ID_W'(idx);
      end
    end
  end

endmodule : pe_rot_encoder
`default_nettype wire

// File: rtl/pe_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pe_rr_arbiter                                                   |
// | Purpose  : Round-robin arbiter with grant hold, a hold-time limit and      |
// |            enable gating. Grants are registered (1 cycle latency).         |
// | Ports    : clk       in   rising-edge clock                                |
// |            rst       in   synchronous active-high reset                    |
// |            arb       if   slave view: en, req in; gnt, gnt_id, gnt_vld out |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module pe_rr_arbiter
  import pe_arb_pkg::*;
#(
  parameter int N        = 3,
  parameter int ID_W     = clog2(N),
  parameter int MAX_HOLD = 4
) (
  input wire logic       clk,
  input wire logic       rst,
  pe_rr_arbiter_if.slave arb
);

  localparam int                HOLD_W      = clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] C_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0]   C_LAST_ID   = ID_W'(N - 1);

  arb_state_e        r_state,    w_state_nxt;
  logic [ID_W-1:0]   r_last_id,  w_last_id_nxt;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_cnt_nxt;
  logic [N-1:0]      r_gnt,      w_gnt_nxt;
  logic [ID_W-1:0]   r_gnt_id,   w_gnt_id_nxt;
  logic              r_gnt_vld,  w_gnt_vld_nxt;

  logic [ID_W-1:0]   w_start;
  logic [N-1:0]      w_holder_mask;
  logic [N-1:0]      w_enc_req;
  logic              w_holder_req;
  logic [ID_W-1:0]   w_win_id;
  logic              w_win_vld;
  logic              w_take;

  // Scan begins just after the last winner, so the last winner is the
  // lowest-priority candidate.
  assign w_start       = (r_last_id == C_LAST_ID) ? '0 : r_last_id + 1'b1;
  assign w_holder_mask = N'(1) << r_last_id;
  assign w_holder_req  = |(arb.req & w_holder_mask);
  // While a grant is held, the encoder only sees the other requesters, so
  // w_win_vld directly means "someone else is waiting".
  assign w_enc_req     = (r_state == ST_GRANT) ? (arb.req & ~w_holder_mask) : arb.req;

  pe_rot_encoder #(
    .N    (N),
    .ID_W (ID_W)
  ) u_rot_encoder (
    .req   (w_enc_req),
    .start (w_start),
    .id    (w_win_id),
    .valid (w_win_vld)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_last_id_nxt  = r_last_id;
    w_hold_cnt_nxt = r_hold_cnt;
    w_gnt_nxt      = r_gnt;
    w_gnt_id_nxt   = r_gnt_id;
    w_gnt_vld_nxt  = r_gnt_vld;
    w_take         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (arb.en && w_win_vld) w_take = 1'b1;
      end
      ST_GRANT: begin
        if (w_holder_req) begin
          if (r_hold_cnt == C_HOLD_LAST) begin
            // Limit reached: hand over only if someone waits and en allows;
            // otherwise the counter simply stays saturated.
            if (arb.en && w_win_vld) w_take = 1'b1;
          end else begin
            w_hold_cnt_nxt = r_hold_cnt + 1'b1;
          end
        end else if (arb.en && w_win_vld) begin
          w_take = 1'b1;
        end else begin
          w_state_nxt    = ST_IDLE;
          w_hold_cnt_nxt = '0;
          w_gnt_nxt      = '0;
          w_gnt_id_nxt   = '0;
          w_gnt_vld_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (w_take) begin
      w_state_nxt    = ST_GRANT;
      w_last_id_nxt  = w_win_id;
      w_hold_cnt_nxt = '0;
      w_gnt_nxt      = N'(1) << w_win_id;
      w_gnt_id_nxt   = w_win_id;
      w_gnt_vld_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last_id  <= C_LAST_ID;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_gnt_vld  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_last_id  <= w_last_id_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_gnt_vld  <= w_gnt_vld_nxt;
    end
  end

  assign arb.gnt     = r_gnt;
  assign arb.gnt_id  = r_gnt_id;
  assign arb.gnt_vld = r_gnt_vld;

endmodule : pe_rr_arbiter
`default_nettype wire

// File: tb/tb_pe_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_pe_rr_arbiter                                                |
// | Purpose  : Directed self-checking bench for pe_rr_arbiter (N=3,           |
// |            MAX_HOLD=4). Inputs change just after the falling edge and      |
// |            outputs are checked on the falling edge.                        |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_pe_rr_arbiter;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  pe_rr_arbiter_if #(.N(3), .ID_W(2)) bus ();

  pe_rr_arbiter #(
    .N        (3),
    .ID_W     (2),
    .MAX_HOLD (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Expected gnt vector; gnt_vld and gnt_id follow from it.
  task automatic expect_gnt(input string tag, input logic [2:0] eg);
    int eid;
    case (eg)
      3'b010:  eid = 1;
      3'b100:  eid = 2;
      default: eid = 0;
    endcase
    check({tag, "/gnt"}, int'(bus.gnt), int'(eg));
    check({tag, "/vld"}, int'(bus.gnt_vld), int'(|eg));
    check({tag, "/id"}, int'(bus.gnt_id), eid);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.req = 3'b000;

    repeat (2) @(negedge clk);
    expect_gnt("reset", 3'b000);

    // 1: all requesting, each holder gets 4 cycles in order 0,1,2,0
    rst     = 1'b0;
    bus.en  = 1'b1;
    bus.req = 3'b111;
    for (int i = 0; i < 13; i++) begin
      logic [2:0] eg;
      @(negedge clk);
      eg = 3'b001 << ((i / 4) % 3);
      expect_gnt($sformatf("rr%0d", i), eg);
    end
    bus.req = 3'b000;
    @(negedge clk);
    expect_gnt("rr_idle", 3'b000);

    // 2: single request for two cycles then released
    bus.req = 3'b010;
    @(negedge clk);
    expect_gnt("single_a", 3'b010);
    @(negedge clk);
    expect_gnt("single_b", 3'b010);
    bus.req = 3'b000;
    @(negedge clk);
    expect_gnt("single_rel", 3'b000);

    // 3: holder 0 releases on the same edge requester 2 arrives
    bus.req = 3'b001;
    @(negedge clk);
    expect_gnt("b2b_first", 3'b001);
    bus.req = 3'b100;
    @(negedge clk);
    expect_gnt("b2b_second", 3'b100);
    bus.req = 3'b000;
    @(negedge clk);
    expect_gnt("b2b_idle", 3'b000);

    // 4: lone holder is never forced off
    bus.req = 3'b001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      expect_gnt($sformatf("lone%0d", i), 3'b001);
    end
    bus.req = 3'b000;
    @(negedge clk);
    expect_gnt("lone_idle", 3'b000);

    // 5: en gating; last winner was 0 so requester 1 wins
    bus.en  = 1'b0;
    bus.req = 3'b110;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_gnt($sformatf("en_off%0d", i), 3'b000);
    end
    bus.en = 1'b1;
    @(negedge clk);
    expect_gnt("en_on", 3'b010);
    bus.en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      expect_gnt($sformatf("en_hold%0d", i), 3'b010);
    end
    bus.en = 1'b1;
    @(negedge clk);
    expect_gnt("en_handover", 3'b100);

    // 6: reset mid-grant, then last_id restarts at 2 so requester 0 wins
    rst = 1'b1;
    @(negedge clk);
    expect_gnt("rst_mid", 3'b000);
    rst     = 1'b0;
    bus.req = 3'b101;
    @(negedge clk);
    expect_gnt("rst_after", 3'b001);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_pe_rr_arbiter
`default_nettype wire
